adc_sample_counter: RTL and testbench
=====================================

ADC_SAMPLE_COUNTER -- requirements
Module: adc_sample_counter

Interface
REQ-001 Parameter WINDOW_CYCLES, default 50000000, gate-window length in clk cycles; legal range 2..2^32-1.
REQ-002 Parameter CNT_W, default 32, width of accumulator and measured_count; legal range 8..32.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  level; high runs back-to-back measurement windows, low idles the block.
REQ-006 sample_in  input  1  ADC conversion-done level/pulse; each rising edge counts one sample.
REQ-007 measured_count  output  CNT_W  samples counted in the last completed window; feeds the downstream PIO in_port, zero-extended to 32 bits.
REQ-008 count_update  output  1  one-cycle pulse, high in the first cycle a new measured_count is visible.
REQ-009 overflow  output  1  high when the last completed window saturated.
REQ-010 window_active  output  1  high while state is RUN.

Function
REQ-011 Rising-edge detect: edge = s & ~s_d, where s is the (optionally synchronized) sample_in and s_d is s delayed one clk.
REQ-012 States IDLE and RUN only; IDLE -> RUN on the first cycle enable=1; RUN -> IDLE on the first cycle enable=0.
REQ-013 On IDLE->RUN: window timer=0, accumulator=0, sat flag=0; edges in the transition cycle are not counted.
REQ-014 In RUN, window timer increments each cycle from 0 to WINDOW_CYCLES-1, then wraps to 0 (terminal cycle = timer at WINDOW_CYCLES-1).
REQ-015 In RUN, non-terminal cycle with edge=1: accumulator+1, saturating at 2^CNT_W-1; reaching saturation with a further edge sets sat flag.
REQ-016 Terminal cycle: measured_count <= accumulator + edge (same saturation rule), overflow <= sat flag OR saturation in that cycle; accumulator <= 0 and sat flag <= 0 on the same edge, so no sample edge is lost or double-counted between windows.
REQ-017 count_update is high exactly in the cycle after the terminal cycle, one cycle wide, once per window.
REQ-018 measured_count and overflow change only at a terminal cycle or reset; they hold otherwise, including through IDLE.
REQ-019 enable falling mid-window: partial window discarded, no count_update, measured_count/overflow hold.
REQ-020 enable=0 and terminal cycle coincide: enable wins, window discarded.
REQ-021 s_d keeps tracking s in IDLE, so a level already high at RUN entry produces no edge.
REQ-022 Window latency: first count_update occurs WINDOW_CYCLES+1 cycles after the first RUN cycle.

Reset
REQ-023 reset_n low asynchronously forces: state=IDLE, timer=0, accumulator=0, sat flag=0, s_d=0, synchronizer flops=0.
REQ-024 Output reset values: measured_count=0, count_update=0, overflow=0, window_active=0.
REQ-025 Reset asserted mid-window discards the window; after release the block re-enters RUN per REQ-012 only if enable=1.

Configuration
REQ-026 Macro ADC_SAMPLE_SYNC_EN defined: sample_in passes a 2-flop synchronizer before edge detect, adding 2 cycles edge-to-count latency.
REQ-027 Macro ADC_SAMPLE_SYNC_EN undefined: sample_in drives edge detect directly (caller guarantees it is clk-synchronous); all other behaviour identical.

Verification (WINDOW_CYCLES=100, CNT_W=32, macro undefined unless stated)
REQ-028 Reset, enable=1, 10 sample_in pulses (1 high, 3 low) inside first window -> count_update at cycle 101 after RUN entry, measured_count=10, overflow=0.
REQ-029 sample_in toggling every cycle continuously -> every window reports 50, updates exactly 100 cycles apart, no edge lost across wrap.
REQ-030 Single edge on terminal cycle of window 1 -> window 1 reports 1; window 2 reports 0.
REQ-031 enable dropped at timer=60 after 5 edges -> no count_update, measured_count holds previous value; re-enable -> fresh window from 0.
REQ-032 CNT_W=8, toggling every cycle with WINDOW_CYCLES=1000 -> measured_count=255, overflow=1; next window with 3 edges -> 3, overflow=0.
REQ-033 ADC_SAMPLE_SYNC_EN defined, edge 1 cycle before terminal cycle -> counted in next window; reset_n pulse mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/adc_sample_counter.sv
// adc_sample_counter: counts rising edges of sample_in over back-to-back gate windows
// of WINDOW_CYCLES clocks. Define ADC_SAMPLE_SYNC_EN to add a 2-flop input synchronizer.
module adc_sample_counter #(
   parameter int unsigned WINDOW_CYCLES = 50000000,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             sample_in,
   output logic [CNT_W-1:0] measured_count,
   output logic             count_update,
   output logic             overflow,
   output logic             window_active
);

   localparam logic [31:0]      LAST_TICK = 32'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [31:0]      timer;
   logic [CNT_W-1:0] accum;
   logic             sat;
   logic             s;
   logic             s_d;
   logic             sample_edge;
   logic             terminal;
   logic             acc_full;

`ifdef ADC_SAMPLE_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], sample_in};
      end
   end

   assign s = sync_q[1];
`else
   assign s = sample_in;
`endif

   // s_d tracks s in every state so a level already high at RUN entry is not an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_d <= 1'b0;
      end else begin
         s_d <= s;
      end
   end

   assign sample_edge = s & ~s_d;
   assign terminal    = (timer == LAST_TICK);
   assign acc_full    = (accum == CNT_MAX);

   // The terminal cycle folds its own edge into the published result and clears the
   // accumulator on the same clock, so the next window starts counting immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         window_active  <= 1'b0;
         timer          <= '0;
         accum          <= '0;
         sat            <= 1'b0;
         measured_count <= '0;
         overflow       <= 1'b0;
         count_update   <= 1'b0;
      end else begin
         count_update <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state         <= RUN;
                  window_active <= 1'b1;
                  timer         <= '0;
                  accum         <= '0;
                  sat           <= 1'b0;
               end
            end
            RUN: begin
               if (!enable) begin
                  state         <= IDLE;
                  window_active <= 1'b0;
               end else if (terminal) begin
                  measured_count <= acc_full ? accum : accum + CNT_W'(sample_edge);
                  overflow       <= sat | (acc_full & sample_edge);
                  count_update   <= 1'b1;
                  accum          <= '0;
                  sat            <= 1'b0;
                  timer          <= '0;
               end else begin
                  timer <= timer + 32'd1;
                  if (sample_edge) begin
                     if (acc_full) begin
                        sat <= 1'b1;
                     end else begin
                        accum <= accum + CNT_W'(1);
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_sample_counter.sv
// Bench for adc_sample_counter: two instances (100-cycle/32-bit and 1000-cycle/8-bit windows)
// share stimulus and are compared every cycle against a window-level edge-counting model.
module tb_adc_sample_counter;

   localparam int W_A = 100;
   localparam int W_B = 1000;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        sample_in;
   logic [31:0] a_count;
   logic        a_upd;
   logic        a_ovf;
   logic        a_active;
   logic [7:0]  b_count;
   logic        b_upd;
   logic        b_ovf;
   logic        b_active;

   int tests_run = 0;
   int failed    = 0;
   int first_upd = 0;

   adc_sample_counter #(.WINDOW_CYCLES(W_A), .CNT_W(32)) dut_a (
      .clk(clk), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
      .measured_count(a_count), .count_update(a_upd), .overflow(a_ovf),
      .window_active(a_active)
   );

   adc_sample_counter #(.WINDOW_CYCLES(W_B), .CNT_W(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
      .measured_count(b_count), .count_update(b_upd), .overflow(b_ovf),
      .window_active(b_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: count all edges seen while running, publish min(total, max) at window end
   int     win   [2] = '{W_A, W_B};
   longint max_c [2] = '{64'hFFFF_FFFF, 64'd255};
   bit     m_run [2];
   int     m_pos [2];
   longint m_cnt [2];
   longint m_count [2];
   bit     m_ovf [2];
   bit     m_upd [2];
   bit     s_prev;
`ifdef ADC_SAMPLE_SYNC_EN
   bit     h1, h2;
`endif

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_prev = 1'b0;
`ifdef ADC_SAMPLE_SYNC_EN
         h1 = 1'b0;
         h2 = 1'b0;
`endif
         for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0; m_pos[k] = 0; m_cnt[k] = 0;
            m_count[k] = 0;  m_ovf[k] = 1'b0; m_upd[k] = 1'b0;
         end
      end else begin
         bit s, e;
`ifdef ADC_SAMPLE_SYNC_EN
         s  = h2;
         h2 = h1;
         h1 = sample_in;
`else
         s = sample_in;
`endif
         e = s & ~s_prev;
         s_prev = s;
         for (int k = 0; k < 2; k++) begin
            m_upd[k] = 1'b0;
            if (!m_run[k]) begin
               if (enable) begin
                  m_run[k] = 1'b1; m_pos[k] = 0; m_cnt[k] = 0;
               end
            end else if (!enable) begin
               m_run[k] = 1'b0;
            end else begin
               m_cnt[k] += longint'(e);
               if (m_pos[k] == win[k] - 1) begin
                  m_count[k] = (m_cnt[k] > max_c[k]) ? max_c[k] : m_cnt[k];
                  m_ovf[k]   = (m_cnt[k] > max_c[k]);
                  m_upd[k]   = 1'b1;
                  m_cnt[k]   = 0;
                  m_pos[k]   = 0;
               end else begin
                  m_pos[k]++;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_output();
      check("a.measured_count", {32'd0, a_count}, 64'(m_count[0]));
      check("a.count_update",   {63'd0, a_upd},   {63'd0, m_upd[0]});
      check("a.overflow",       {63'd0, a_ovf},   {63'd0, m_ovf[0]});
      check("a.window_active",  {63'd0, a_active}, {63'd0, m_run[0]});
      check("b.measured_count", {56'd0, b_count}, 64'(m_count[1]));
      check("b.count_update",   {63'd0, b_upd},   {63'd0, m_upd[1]});
      check("b.overflow",       {63'd0, b_ovf},   {63'd0, m_ovf[1]});
      check("b.window_active",  {63'd0, b_active}, {63'd0, m_run[1]});
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check_output();
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b0;
      sample_in = 1'b0;
      repeat (3) @(negedge clk);
      check_output();
      check("reset.a_count", {32'd0, a_count}, 64'd0);
      check("reset.b_count", {56'd0, b_count}, 64'd0);
      check("reset.a_active", {63'd0, a_active}, 64'd0);

      // 10 pulses (1 high, 3 low) in window 1, then continuous toggling, then 3 pulses
      reset_n = 1'b1;
      enable  = 1'b1;
      for (int n = 1; n <= 2100; n++) begin
         if (n >= 2 && n <= 41)
            sample_in = (n % 4 == 2);
         else if (n >= 102 && n < 900)
            sample_in = ~sample_in;
         else
            sample_in = (n == 1200 || n == 1204 || n == 1208);
         step();
         if (a_upd && first_upd == 0) begin
            first_upd = n;
            check("a.first_window_count", {32'd0, a_count}, 64'd10);
            check("a.first_window_ovf", {63'd0, a_ovf}, 64'd0);
         end
         if (n == 500) check("a.toggle_window_count", {32'd0, a_count}, 64'd50);
         if (n == 1100) begin
            check("b.saturated_count", {56'd0, b_count}, 64'd255);
            check("b.saturated_ovf", {63'd0, b_ovf}, 64'd1);
         end
         if (n == 2100) begin
            check("b.after_sat_count", {56'd0, b_count}, 64'd3);
            check("b.after_sat_ovf", {63'd0, b_ovf}, 64'd0);
         end
      end
      check("a.first_update_latency", 64'(first_upd), 64'd101);

      // Enable drop mid-window with a few edges pending, then re-enable
      for (int n = 0; n < 60; n++) begin
         sample_in = (n % 8 == 0);
         step();
      end
      enable = 1'b0;
      for (int n = 0; n < 20; n++) step();
      check("a.hold_in_idle", {63'd0, a_active}, 64'd0);
      enable = 1'b1;
      for (int n = 0; n < 250; n++) begin
         sample_in = (n % 6 == 0);
         step();
      end

      // Randomized traffic with occasional enable toggles
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         sample_in = ($urandom_range(0, 2) == 0);
         step();
      end

      // Asynchronous reset in the middle of a window
      enable = 1'b1;
      for (int n = 0; n < 150; n++) begin
         sample_in = ~sample_in;
         step();
      end
      #1 reset_n = 1'b0;
      #1;
      check("async_reset.a_count", {32'd0, a_count}, 64'd0);
      check("async_reset.a_ovf", {63'd0, a_ovf}, 64'd0);
      check("async_reset.a_active", {63'd0, a_active}, 64'd0);
      check("async_reset.b_count", {56'd0, b_count}, 64'd0);
      check("async_reset.b_upd", {63'd0, b_upd}, 64'd0);
      @(negedge clk);
      check_output();
      reset_n = 1'b1;
      for (int n = 0; n < 250; n++) begin
         sample_in = ($urandom_range(0, 1) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
